// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: instruction fetch front end.
//   Issues pipelined reads to instruction memory (up to MaxOutstanding in
//   flight). Returned words are queued with their PCs in a 2**DepthLog2
//   entry queue. A redirect flushes the queue in the same cycle, and responses
//   still in flight are discarded as they return.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   instmem_valid_o/ready_i/addr_o  read request handshake
//   instmem_rvalid_i/rdata_i      in-order read responses
//   redirect_valid_i/pc_i         taken branch/jump target
//   inst_valid_o/ready_i/pc_o/data_o  {pc, instr} to decode
module fetch_unit #(
  parameter int unsigned     Xlen           = 32,
  parameter int unsigned     Ilen           = 32,
  parameter int unsigned     DepthLog2      = 2,
  parameter int unsigned     MaxOutstanding = 2,
  parameter logic [Xlen-1:0] ResetPc        = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            instmem_ready_i,
  output logic            instmem_valid_o,
  output logic [Xlen-1:0] instmem_addr_o,
  input  logic [Ilen-1:0] instmem_rdata_i,
  input  logic            instmem_rvalid_i,
  input  logic            redirect_valid_i,
  input  logic [Xlen-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  output logic [Xlen-1:0] inst_pc_o,
  output logic [Ilen-1:0] inst_data_o,
  input  logic            inst_ready_i
);
  localparam int unsigned Depth = 2**DepthLog2;
  localparam int unsigned CW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned TW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned QCW   = DepthLog2 + 1;
  localparam int unsigned SW    = DepthLog2 + 2;

  logic [Xlen-1:0]      fetch_pc_q, fetch_pc_d;
  // inflight counts every accepted read not yet returned; drop is the
  // subset of those that belong to a flushed stream.
  logic [CW-1:0]        inflight_q, inflight_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic [TW-1:0]        trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;
  logic [DepthLog2-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [QCW-1:0]       q_cnt_q, q_cnt_d;

  logic [Xlen-1:0] trk_pc_q [MaxOutstanding];
  logic [Xlen-1:0] q_pc_q   [Depth];
  logic [Ilen-1:0] q_data_q [Depth];

  logic [Xlen-1:0] redirect_addr;
  logic            credit, accept, push, pop;

  function automatic logic [TW-1:0] trk_inc(input logic [TW-1:0] p);
    return (p == TW'(MaxOutstanding - 1)) ? '0 : p + TW'(1);
  endfunction

  assign redirect_addr = redirect_pc_i & ~Xlen'(3);

  // Reserving a queue slot for every read in flight (stale ones included)
  // means a response can always be enqueued without backpressure.
  assign credit = (({{(SW-CW){1'b0}}, inflight_q} + {1'b0, q_cnt_q}) < SW'(Depth))
               && (inflight_q < CW'(MaxOutstanding));

  assign instmem_valid_o = credit & rst_ni;
  assign instmem_addr_o  = redirect_valid_i ? redirect_addr : fetch_pc_q;
  assign accept          = instmem_valid_o & instmem_ready_i;
  // A response arriving alongside a redirect belongs to the old stream.
  assign push            = instmem_rvalid_i & (drop_q == '0) & ~redirect_valid_i;
  assign pop             = inst_valid_o & inst_ready_i & ~redirect_valid_i;

  assign inst_valid_o = (q_cnt_q != '0);
  assign inst_pc_o    = q_pc_q[q_rd_q];
  assign inst_data_o  = q_data_q[q_rd_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (accept)                fetch_pc_d = instmem_addr_o + Xlen'(4);
    else if (redirect_valid_i) fetch_pc_d = redirect_addr;

    inflight_d = inflight_q + CW'(accept) - CW'(instmem_rvalid_i);
    trk_wr_d   = accept           ? trk_inc(trk_wr_q) : trk_wr_q;
    trk_rd_d   = instmem_rvalid_i ? trk_inc(trk_rd_q) : trk_rd_q;

    drop_d = drop_q;
    // Everything outstanding before the redirect becomes stale, minus the
    // one response retiring right now.
    if (redirect_valid_i)
      drop_d = inflight_q - CW'(instmem_rvalid_i);
    else if (instmem_rvalid_i && (drop_q != '0))
      drop_d = drop_q - CW'(1);

    q_wr_d  = push ? q_wr_q + DepthLog2'(1) : q_wr_q;
    q_rd_d  = pop  ? q_rd_q + DepthLog2'(1) : q_rd_q;
    q_cnt_d = q_cnt_q + QCW'(push) - QCW'(pop);
    if (redirect_valid_i) begin
      q_wr_d  = '0;
      q_rd_d  = '0;
      q_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= ResetPc;
      inflight_q <= '0;
      drop_q     <= '0;
      trk_wr_q   <= '0;
      trk_rd_q   <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
      q_cnt_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      trk_wr_q   <= trk_wr_d;
      trk_rd_q   <= trk_rd_d;
      q_wr_q     <= q_wr_d;
      q_rd_q     <= q_rd_d;
      q_cnt_q    <= q_cnt_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers above.
  always_ff @(posedge clk_i) begin
    if (accept) trk_pc_q[trk_wr_q] <= instmem_addr_o;
    if (push) begin
      q_pc_q[q_wr_q]   <= trk_pc_q[trk_rd_q];
      q_data_q[q_wr_q] <= instmem_rdata_i;
    end
  end

  a_rvalid_tracked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instmem_rvalid_i |-> (inflight_q != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && !pop) |-> (q_cnt_q != QCW'(Depth)));
endmodule
